// File: rtl/oled_pkg.sv
// Shared types and constants for the OLED SPI link monitor.
package oled_pkg;

  typedef enum logic [1:0] {
    LINK_OFF    = 2'd0,
    LINK_RESET  = 2'd1,
    LINK_ACTIVE = 2'd2
  } link_state_e;

  localparam logic [7:0] OLED_CMD_DISP_ON  = 8'hAF;
  localparam logic [7:0] OLED_CMD_DISP_OFF = 8'hAE;

  // 128x32 panel, each display byte covers one column of an 8-row page.
  localparam int OLED_COLS        = 128;
  localparam int OLED_ROWS        = 32;
  localparam int OLED_PAGES       = OLED_ROWS / 8;
  localparam int OLED_FRAME_BYTES = OLED_COLS * OLED_PAGES;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser for a small bus plus a registered rising-edge pulse on bit 0.
// sync_out is delayed to line up with rise so sampled data matches the detected edge.
module sync_edge #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] sync_out,
  output logic             rise
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0] align_q, align_d;
  logic             rise_q, rise_d;

  always_comb begin
    meta_d  = din;
    sync_d  = meta_q;
    align_d = sync_q;
    rise_d  = sync_q[0] & ~align_q[0];
  end

  // NOTE: sequential state always uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q  <= '0;
      sync_q  <= '0;
      align_q <= '0;
      rise_q  <= 1'b0;
    end else begin
      meta_q  <= meta_d;
      sync_q  <= sync_d;
      align_q <= align_d;
      rise_q  <= rise_d;
    end
  end

  assign sync_out = align_q;
  assign rise     = rise_q;

endmodule

// File: rtl/oled_spi_monitor.sv
// Passive receiver for the OLED SPI link: rebuilds MSB-first bytes, tags command/data,
// tracks display on/off, frame completion, dropped partial bytes and the link power state.
module oled_spi_monitor
  import oled_pkg::*;
#(
  parameter int idle_timeout = 1000,
  parameter int frame_bytes  = OLED_FRAME_BYTES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       sdo,
  input  logic       dc,
  input  logic       res,
  input  logic       vdd,
  input  logic       vbat,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_is_data,
  output logic       display_on,
  output logic       frame_done,
  output logic       framing_err,
  output logic [1:0] link_state
);

  localparam int DCNT_W = (frame_bytes > 1) ? $clog2(frame_bytes) : 1;
  localparam int IDLE_W = $clog2(idle_timeout + 1);
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(frame_bytes - 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(idle_timeout);

  logic [2:0] sync_bus;
  logic       sclk_rise;
  logic       sdo_s, dc_s;
  logic       unused_sclk_level;

  sync_edge #(.WIDTH(3)) u_sync (
    .clk      (clk),
    .rst      (rst),
    .din      ({dc, sdo, sclk}),
    .sync_out (sync_bus),
    .rise     (sclk_rise)
  );

  assign sdo_s             = sync_bus[1];
  assign dc_s              = sync_bus[2];
  assign unused_sclk_level = sync_bus[0];

  link_state_e state_q, state_d;
  logic        accept, flush;

  always_ff @(posedge clk) begin
    if (rst) state_q <= LINK_OFF;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (vdd)       state_d = LINK_OFF;
    else if (!res) state_d = LINK_RESET;
    else           state_d = LINK_ACTIVE;
  end

  // Edges count only once already Active, so a release of res on the same cycle as an edge drops that edge.
  always_comb begin
    accept     = (state_q == LINK_ACTIVE);
    flush      = (state_d != LINK_ACTIVE);
    link_state = state_q;
  end

  logic [7:0]        shift_q, shift_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [DCNT_W-1:0] data_cnt_q, data_cnt_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              disp_q, disp_d;
  logic [7:0]        byte_data_q, byte_data_d;
  logic              byte_is_data_q, byte_is_data_d;
  logic              byte_valid_q, byte_valid_d;
  logic              frame_done_q, frame_done_d;
  logic              framing_err_q, framing_err_d;

  // NOTE: every signal gets a default at the top of the block so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    shift_d        = shift_q;
    bit_cnt_d      = bit_cnt_q;
    data_cnt_d     = data_cnt_q;
    disp_d         = disp_q;
    byte_data_d    = byte_data_q;
    byte_is_data_d = byte_is_data_q;
    byte_valid_d   = 1'b0;
    frame_done_d   = 1'b0;
    framing_err_d  = 1'b0;

    if (sclk_rise)               idle_d = '0;
    else if (idle_q != IDLE_MAX) idle_d = idle_q + 1'b1;
    else                         idle_d = idle_q;

    if (flush) begin
      shift_d    = '0;
      bit_cnt_d  = '0;
      data_cnt_d = '0;
      disp_d     = 1'b0;
    end else if (accept && sclk_rise) begin
      shift_d = {shift_q[6:0], sdo_s};
      if (bit_cnt_q == 3'd7) begin
        bit_cnt_d      = '0;
        byte_data_d    = shift_d;
        byte_is_data_d = dc_s;
        byte_valid_d   = 1'b1;
        if (dc_s) begin
          if (data_cnt_q == DCNT_LAST) begin
            data_cnt_d   = '0;
            frame_done_d = 1'b1;
          end else begin
            data_cnt_d = data_cnt_q + 1'b1;
          end
        end else if (shift_d == OLED_CMD_DISP_ON) begin
          disp_d = 1'b1;
        end else if (shift_d == OLED_CMD_DISP_OFF) begin
          disp_d = 1'b0;
        end
      end else begin
        bit_cnt_d = bit_cnt_q + 3'd1;
      end
    end else if (accept && bit_cnt_q != 3'd0 && idle_q != IDLE_MAX && idle_d == IDLE_MAX) begin
      bit_cnt_d     = '0;
      framing_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q        <= '0;
      bit_cnt_q      <= '0;
      data_cnt_q     <= '0;
      idle_q         <= '0;
      disp_q         <= 1'b0;
      byte_data_q    <= '0;
      byte_is_data_q <= 1'b0;
      byte_valid_q   <= 1'b0;
      frame_done_q   <= 1'b0;
      framing_err_q  <= 1'b0;
    end else begin
      shift_q        <= shift_d;
      bit_cnt_q      <= bit_cnt_d;
      data_cnt_q     <= data_cnt_d;
      idle_q         <= idle_d;
      disp_q         <= disp_d;
      byte_data_q    <= byte_data_d;
      byte_is_data_q <= byte_is_data_d;
      byte_valid_q   <= byte_valid_d;
      frame_done_q   <= frame_done_d;
      framing_err_q  <= framing_err_d;
    end
  end

  assign byte_valid   = byte_valid_q;
  assign byte_data    = byte_data_q;
  assign byte_is_data = byte_is_data_q;
  assign display_on   = disp_q & ~vbat;
  assign frame_done   = frame_done_q;
  assign framing_err  = framing_err_q;

endmodule

// File: tb/tb_oled_spi_monitor.sv
// Directed self-checking bench for oled_spi_monitor driven as the OLED controller would.
module tb_oled_spi_monitor;

  logic       clk = 1'b0;
  logic       rst, sclk, sdo, dc, res, vdd, vbat;
  logic       byte_valid, byte_is_data, display_on, frame_done, framing_err;
  logic [7:0] byte_data;
  logic [1:0] link_state;

  int checks = 0;
  int errors = 0;

  int bv_cnt = 0, fd_cnt = 0, fe_cnt = 0, fd_bv_idx = 0;
  logic fd_with_bv = 1'b0;

  oled_spi_monitor dut (
    .clk          (clk),
    .rst          (rst),
    .sclk         (sclk),
    .sdo          (sdo),
    .dc           (dc),
    .res          (res),
    .vdd          (vdd),
    .vbat         (vbat),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_is_data (byte_is_data),
    .display_on   (display_on),
    .frame_done   (frame_done),
    .framing_err  (framing_err),
    .link_state   (link_state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (byte_valid) bv_cnt++;
    if (frame_done) begin
      fd_cnt++;
      fd_with_bv = byte_valid;
      fd_bv_idx  = bv_cnt;
    end
    if (framing_err) fe_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Minimum legal phases: 3 clk low, 3 clk high; sdo changes with the falling edge.
  task automatic send_bit(input logic b);
    sdo  = b;
    sclk = 1'b0;
    repeat (3) tick();
    sclk = 1'b1;
    repeat (3) tick();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic dc_v);
    dc = dc_v;
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  int bv_base, fd_base, fe_base;

  initial begin
    rst = 1'b1; sclk = 1'b0; sdo = 1'b0; dc = 1'b0;
    res = 1'b0; vdd = 1'b0; vbat = 1'b0;
    repeat (3) tick();

    check("rst_link_state", 32'(link_state), 32'd0);
    check("rst_byte_valid", 32'(byte_valid), 32'd0);
    check("rst_byte_data", 32'(byte_data), 32'h00);
    check("rst_display_on", 32'(display_on), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_framing_err", 32'(framing_err), 32'd0);

    rst = 1'b0;
    tick();
    check("link_reset", 32'(link_state), 32'd1);
    res = 1'b1;
    tick();
    check("link_active", 32'(link_state), 32'd2);

    // Display off then on commands.
    bv_base = bv_cnt;
    send_byte(8'hAE, 1'b0);
    repeat (4) tick();
    check("cmd_ae_data", 32'(byte_data), 32'hAE);
    check("cmd_ae_is_data", 32'(byte_is_data), 32'd0);
    check("cmd_ae_disp", 32'(display_on), 32'd0);
    send_byte(8'hAF, 1'b0);
    repeat (4) tick();
    check("cmd_af_data", 32'(byte_data), 32'hAF);
    check("cmd_af_is_data", 32'(byte_is_data), 32'd0);
    check("cmd_af_disp", 32'(display_on), 32'd1);
    check("cmd_bv_count", 32'(bv_cnt - bv_base), 32'd2);
    vbat = 1'b1;
    tick();
    check("vbat_gates_disp", 32'(display_on), 32'd0);
    vbat = 1'b0;
    tick();
    check("vbat_ungated_disp", 32'(display_on), 32'd1);

    // One full frame of data bytes.
    bv_base = bv_cnt;
    fd_base = fd_cnt;
    for (int i = 0; i < 512; i++) send_byte(8'(i), 1'b1);
    repeat (4) tick();
    check("frame_bv_count", 32'(bv_cnt - bv_base), 32'd512);
    check("frame_fd_count", 32'(fd_cnt - fd_base), 32'd1);
    check("frame_fd_index", 32'(fd_bv_idx - bv_base), 32'd512);
    check("frame_fd_with_bv", 32'(fd_with_bv), 32'd1);
    check("frame_last_data", 32'(byte_data), 32'hFF);
    check("frame_is_data", 32'(byte_is_data), 32'd1);

    // Partial byte then idle timeout.
    bv_base = bv_cnt;
    fe_base = fe_cnt;
    dc = 1'b0;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    for (int i = 0; i < 1100; i++) tick();
    check("idle_fe_count", 32'(fe_cnt - fe_base), 32'd1);
    check("idle_no_bv", 32'(bv_cnt - bv_base), 32'd0);
    send_byte(8'h3C, 1'b0);
    repeat (4) tick();
    check("after_idle_data", 32'(byte_data), 32'h3C);
    check("after_idle_bv", 32'(bv_cnt - bv_base), 32'd1);
    check("undecoded_cmd_disp", 32'(display_on), 32'd1);
    for (int i = 0; i < 1100; i++) tick();
    check("idle_aligned_no_fe", 32'(fe_cnt - fe_base), 32'd1);

    // Panel reset mid-frame.
    for (int i = 0; i < 100; i++) send_byte(8'(i), 1'b1);
    repeat (4) tick();
    check("midframe_link", 32'(link_state), 32'd2);
    res = 1'b0;
    tick();
    check("res_low_link", 32'(link_state), 32'd1);
    check("res_low_disp", 32'(display_on), 32'd0);
    repeat (5) tick();
    res = 1'b1;
    tick();
    check("res_release_link", 32'(link_state), 32'd2);
    check("res_release_disp", 32'(display_on), 32'd0);
    bv_base = bv_cnt;
    fd_base = fd_cnt;
    for (int i = 0; i < 512; i++) send_byte(8'(i), 1'b1);
    repeat (4) tick();
    check("refill_fd_count", 32'(fd_cnt - fd_base), 32'd1);
    check("refill_fd_index", 32'(fd_bv_idx - bv_base), 32'd512);

    // Logic supply off: edges ignored.
    vdd = 1'b1;
    tick();
    check("vdd_off_link", 32'(link_state), 32'd0);
    bv_base = bv_cnt;
    send_byte(8'hFF, 1'b0);
    repeat (4) tick();
    check("vdd_off_no_bv", 32'(bv_cnt - bv_base), 32'd0);
    check("vdd_off_link_hold", 32'(link_state), 32'd0);
    vdd = 1'b0;
    tick();
    check("vdd_on_link", 32'(link_state), 32'd2);

    // Latency at minimum phases for 0xA5 (1010_0101).
    bv_base = bv_cnt;
    dc = 1'b1;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    sdo  = 1'b1;
    sclk = 1'b0;
    repeat (3) tick();
    sclk = 1'b1;
    repeat (3) tick();
    check("lat_not_early", 32'(byte_valid), 32'd0);
    tick();
    check("lat_edge_n3", 32'(byte_valid), 32'd1);
    check("lat_data", 32'(byte_data), 32'hA5);
    tick();
    check("lat_single_pulse", 32'(byte_valid), 32'd0);
    check("lat_bv_count", 32'(bv_cnt - bv_base), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
